// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side handshake bundle for the UART receiver: byte, status flags and ACK.
interface uart_rx_ctrl_if;
  logic       ACK;
  logic [7:0] DATA;
  logic       VALID;
  logic       BUSY;
  logic       FRAME_ERR;
  logic       OVERRUN;

  // Receiver side drives data and status, consumes ACK
  modport slave (
    input  ACK,
    output DATA, VALID, BUSY, FRAME_ERR, OVERRUN
  );

  // Memory/IO side pulses ACK and reads data and status
  modport master (
    output ACK,
    input  DATA, VALID, BUSY, FRAME_ERR, OVERRUN
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronises UART_RX, deserialises LSB-first frames into a
// one-byte holding register and hands it out over a VALID/ACK handshake with
// sticky framing and overrun flags. CLKS_PER_BIT must be at least 4.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         UART_RX,
  uart_rx_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = 13;
  localparam logic [TIMER_W-1:0] BIT_END  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_END = TIMER_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift;
  logic                 rx_meta;
  logic                 rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with bit timer, shifter, holding register and status flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      bus.DATA      <= '0;
      bus.VALID     <= 1'b0;
      bus.BUSY      <= 1'b0;
      bus.FRAME_ERR <= 1'b0;
      bus.OVERRUN   <= 1'b0;
    end else begin
      // ACK clears flags set in earlier cycles; sets below in this cycle win
      if (bus.ACK) begin
        bus.VALID     <= 1'b0;
        bus.FRAME_ERR <= 1'b0;
        bus.OVERRUN   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state    <= ST_START;
            bus.BUSY <= 1'b1;
          end
        end

        ST_START: begin
          if (timer == HALF_END) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              // Start bit did not survive to mid-point: drop it silently
              state    <= ST_IDLE;
              bus.BUSY <= 1'b0;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        ST_DATA: begin
          if (timer == BIT_END) begin
            timer   <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'(1);
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        ST_STOP: begin
          if (timer == BIT_END) begin
            timer <= '0;
            if (rx_s) begin
              bus.DATA  <= shift;
              bus.VALID <= 1'b1;
              if (bus.VALID && !bus.ACK) begin
                bus.OVERRUN <= 1'b1;
              end
              state    <= ST_IDLE;
              bus.BUSY <= 1'b0;
            end else begin
              bus.FRAME_ERR <= 1'b1;
              state         <= ST_BREAK;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        ST_BREAK: begin
          // Hold off until the line goes high so a held-low line is not a new start
          timer <= '0;
          if (rx_s) begin
            state    <= ST_IDLE;
            bus.BUSY <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          timer    <= '0;
          bus.BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 16;

  logic CLK = 1'b0;
  logic RESET;
  logic UART_RX;

  int vectors     = 0;
  int miscompares = 0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .UART_RX (UART_RX),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    UART_RX = v;
    tick(CPB);
  endtask

  // Start bit and 8 data bits, then the stop level is put on the line and the
  // task returns 144 rising edges after the start bit was driven. With two
  // synchroniser stages plus the detect edge, the stop-bit sample (delivery)
  // lands on the 155th rising edge after the start bit: 3 + 8 + 9*16.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    UART_RX = stop_bit;
  endtask

  // Whole frame with a good stop bit; returns with the line idle, byte delivered
  task automatic send_full(input logic [7:0] b);
    send_frame(b, 1'b1);
    tick(CPB);
  endtask

  task automatic pulse_ack();
    bus.ACK = 1'b1;
    tick(1);
    bus.ACK = 1'b0;
  endtask

  initial begin
    RESET   = 1'b1;
    UART_RX = 1'b1;
    bus.ACK = 1'b0;
    tick(3);
    RESET = 1'b0;
    chk_byte("reset_data", bus.DATA, 8'h00);
    chk_bit("reset_valid", bus.VALID, 1'b0);
    chk_bit("reset_busy", bus.BUSY, 1'b0);
    chk_bit("reset_ferr", bus.FRAME_ERR, 1'b0);
    chk_bit("reset_ovr", bus.OVERRUN, 1'b0);
    tick(5);

    // 1: 0x55, exact delivery latency, then ACK
    send_frame(8'h55, 1'b1);
    chk_bit("t1_busy_stop", bus.BUSY, 1'b1);
    tick(10);
    chk_bit("t1_valid_early", bus.VALID, 1'b0);
    tick(1);
    chk_bit("t1_valid", bus.VALID, 1'b1);
    chk_byte("t1_data", bus.DATA, 8'h55);
    chk_bit("t1_ferr", bus.FRAME_ERR, 1'b0);
    chk_bit("t1_busy", bus.BUSY, 1'b0);
    pulse_ack();
    chk_bit("t1_valid_ack", bus.VALID, 1'b0);
    chk_byte("t1_data_ack", bus.DATA, 8'h55);
    tick(10);

    // 2: 4-cycle glitch; BUSY high for exactly 8 cycles
    UART_RX = 1'b0;
    tick(4);
    UART_RX = 1'b1;
    chk_bit("t2_busy_first", bus.BUSY, 1'b1);
    tick(6);
    chk_bit("t2_busy_last", bus.BUSY, 1'b1);
    tick(1);
    chk_bit("t2_busy_end", bus.BUSY, 1'b0);
    chk_bit("t2_valid", bus.VALID, 1'b0);
    chk_bit("t2_ferr", bus.FRAME_ERR, 1'b0);
    chk_bit("t2_ovr", bus.OVERRUN, 1'b0);
    tick(10);

    // 3: 0xA3 with low stop bit, line held low, then a good 0x3C
    send_frame(8'hA3, 1'b0);
    tick(11);
    chk_bit("t3_ferr", bus.FRAME_ERR, 1'b1);
    chk_bit("t3_valid", bus.VALID, 1'b0);
    chk_byte("t3_data_kept", bus.DATA, 8'h55);
    chk_bit("t3_busy_break", bus.BUSY, 1'b1);
    tick(30);
    chk_bit("t3_busy_held", bus.BUSY, 1'b1);
    UART_RX = 1'b1;
    tick(2);
    chk_bit("t3_busy_sync", bus.BUSY, 1'b1);
    tick(1);
    chk_bit("t3_busy_idle", bus.BUSY, 1'b0);
    tick(10);
    send_full(8'h3C);
    chk_bit("t3_valid_3c", bus.VALID, 1'b1);
    chk_byte("t3_data_3c", bus.DATA, 8'h3C);
    chk_bit("t3_ferr_sticky", bus.FRAME_ERR, 1'b1);
    pulse_ack();
    chk_bit("t3_valid_ack", bus.VALID, 1'b0);
    chk_bit("t3_ferr_ack", bus.FRAME_ERR, 1'b0);
    tick(10);

    // 4: overrun from two unacknowledged bytes
    send_full(8'h12);
    chk_byte("t4_data_12", bus.DATA, 8'h12);
    chk_bit("t4_ovr_first", bus.OVERRUN, 1'b0);
    send_full(8'h34);
    chk_byte("t4_data_34", bus.DATA, 8'h34);
    chk_bit("t4_valid", bus.VALID, 1'b1);
    chk_bit("t4_ovr", bus.OVERRUN, 1'b1);
    pulse_ack();
    chk_bit("t4_valid_ack", bus.VALID, 1'b0);
    chk_bit("t4_ovr_ack", bus.OVERRUN, 1'b0);
    tick(10);

    // 5: reset in the middle of data bit 3, then a clean 0xC5
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    UART_RX = 1'b1;
    tick(8);
    chk_bit("t5_busy_pre", bus.BUSY, 1'b1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk_bit("t5_busy", bus.BUSY, 1'b0);
    chk_bit("t5_valid", bus.VALID, 1'b0);
    chk_byte("t5_data", bus.DATA, 8'h00);
    tick(40);
    chk_bit("t5_busy_idle", bus.BUSY, 1'b0);
    send_full(8'hC5);
    chk_bit("t5_valid_c5", bus.VALID, 1'b1);
    chk_byte("t5_data_c5", bus.DATA, 8'hC5);
    pulse_ack();
    tick(10);

    // 6: back-to-back 0x01 / 0xFE, ACK on the 0xFE delivery cycle
    send_full(8'h01);
    chk_byte("t6_data_01", bus.DATA, 8'h01);
    send_frame(8'hFE, 1'b1);
    tick(10);
    chk_bit("t6_valid_pre", bus.VALID, 1'b1);
    chk_byte("t6_data_pre", bus.DATA, 8'h01);
    pulse_ack();
    chk_byte("t6_data", bus.DATA, 8'hFE);
    chk_bit("t6_valid", bus.VALID, 1'b1);
    chk_bit("t6_ovr", bus.OVERRUN, 1'b0);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- 8N1 UART receiver: the receive-side counterpart of UART_TX_CTRL.
- Samples the asynchronous serial line UART_RX in the CLK_50MHz domain and deserialises LSB-first frames into a one-byte holding register.
- Presents each byte to the memory/IO system over a VALID/ACK handshake.
- Reports framing and overrun errors as sticky flags readable through the UART control word.

Parameters:
- CLKS_PER_BIT, 5208, CLK cycles per bit period (50 MHz / 9600 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), cycles from start-edge detection to the start-bit mid-point check.

Ports:
- CLK  input  1  system clock (CLK_50MHz at top level)
- RESET  input  1  synchronous, active-high reset
- UART_RX  input  1  asynchronous serial line; idles high
- ACK  input  1  consumer pulse: pops DATA and clears VALID, FRAME_ERR and OVERRUN
- DATA  output  8  last correctly framed byte
- VALID  output  1  DATA holds an unread byte
- BUSY  output  1  high whenever the FSM is not in IDLE
- FRAME_ERR  output  1  sticky: a stop bit was sampled low
- OVERRUN  output  1  sticky: a byte was delivered while VALID=1 and not acknowledged

Behaviour:
- Reset (synchronous, active-high), applied on the next CLK edge from any state:
  - DATA=0, VALID=0, BUSY=0, FRAME_ERR=0, OVERRUN=0.
  - Synchronizer flops=1, state=IDLE, timer=0, bit count=0, shift register=0.
- Input synchronisation:
  - rx_s is UART_RX passed through two flops.
  - All FSM decisions use rx_s only; UART_RX is never used directly.
- Timer: 13-bit up-counter, cleared on every state transition.
- FSM states:
  - IDLE: rx_s==0 -> START.
  - START: at timer==HALF_BIT-1, if rx_s==0 -> DATA with bit count=0; if rx_s==1 -> IDLE (glitch rejected, nothing reported).
  - DATA: at each timer==CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, LSB-first) and increment bit count. After the 8th sample -> STOP.
  - STOP: at timer==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: DATA<=shift, VALID<=1 -> IDLE.
    - rx_s==0: FRAME_ERR<=1, byte discarded, DATA and VALID unchanged -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. Prevents a held-low line from being taken as a new start bit.
- Latency: VALID rises (HALF_BIT + 9*CLKS_PER_BIT) cycles after the first cycle rx_s is low, +/-0.
- BUSY is a registered decode, high in every state except IDLE.
- Handshake:
  - ACK with VALID=1 clears VALID on the next edge. DATA keeps its value.
  - ACK also clears FRAME_ERR and OVERRUN, regardless of VALID.
- Simultaneous events:
  - Delivery in the same cycle as ACK: the new byte is loaded, VALID stays 1, OVERRUN is not set; the ACK clears only the flags set before that cycle.
  - Delivery with VALID=1 and no ACK: DATA is overwritten with the new byte, OVERRUN<=1.
  - Frame error in the same cycle as ACK: FRAME_ERR ends at 1 (the set wins).
- The receiver never stalls. A byte that is not acknowledged is lost only through overwrite.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8, ideal 16-cycle bits):
1. Send 0x55 with a good stop bit -> after 152 cycles from rx_s falling, VALID=1, DATA=0x55, FRAME_ERR=0, BUSY=0. Pulse ACK -> VALID=0 next cycle, DATA still 0x55.
2. Drive UART_RX low for 4 cycles, then high -> BUSY pulses high for 8 cycles, VALID stays 0, all flags stay 0.
3. Send 0xA3 with the stop bit low, then hold the line low for 40 cycles -> FRAME_ERR=1, VALID=0, BUSY stays 1 until the line returns high. A following 0x3C frame is received correctly.
4. Send 0x12, then 0x34, with no ACK -> DATA=0x34, VALID=1, OVERRUN=1. ACK -> VALID=0, OVERRUN=0.
5. Assert RESET for 1 cycle during data bit 3 of a frame -> next cycle BUSY=0, VALID=0, DATA=0x00. A subsequent 0xC5 frame is received as 0xC5.
6. Send back-to-back 0x01 and 0xFE, with ACK asserted exactly on the 0xFE delivery cycle -> DATA=0xFE, VALID=1, OVERRUN=0.
